piso_serializer64: RTL and testbench
====================================

# piso_serializer64

Parallel-in, serial-out transmitter that converts a WIDTH-bit word into a gated serial bit stream. It drives the 64-bit serial-in shift-register receiver: `o_data` feeds the receiver's `i_data` and `o_enable` feeds its `i_enable`. Words are transmitted MSB first, so after WIDTH shifted bits the receiver holds the original word with bit ordering intact. The block accepts words through a valid/ready handshake and supports back-to-back words with no gap in `o_enable`.

## Interface
- `WIDTH`, default 64: word width and number of serial bits per frame; minimum 2.
- `CW`, default 6: counter width, equal to ceil(log2(WIDTH)).

- `clk` input 1: single clock; all activity on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `i_word` input WIDTH: parallel word to transmit; sampled only on an accepted handshake.
- `i_valid` input 1: `i_word` is valid.
- `o_ready` output 1: block can accept a word this cycle.
- `o_data` output 1: serial bit, registered.
- `o_enable` output 1: serial bit valid, registered; connects to the receiver's `i_enable`.
- `o_last` output 1: high during the final (LSB) bit of a frame.
- `o_done` output 1: one-cycle pulse in the cycle after the last bit; the receiver's parallel output holds the complete word in this cycle.

## Operation
- Two states: IDLE and SHIFT. Internal state consists of a WIDTH-bit shift register, a CW-bit bit counter, and a state register.
- Accept condition: `i_valid && o_ready` at a rising edge.
- `o_ready` is 1 in IDLE. In SHIFT it is 1 only while `o_last` = 1. It is 0 whenever `rst` = 1.
- IDLE, on accept:
  - load `i_word` into the shift register;
  - set `o_data` to `i_word[WIDTH-1]` and `o_enable` to 1;
  - set the counter to 0 and go to SHIFT.
- IDLE, no accept: `o_enable` = 0 and `o_data` = 0.
- SHIFT, each edge while the counter is below WIDTH-1:
  - shift the register left by 1, filling with 0;
  - drive the new MSB on `o_data` and increment the counter.
- `o_last` = 1 when in SHIFT and the counter equals WIDTH-1.
- SHIFT, at the edge ending the last bit:
  - On accept (back-to-back): load the new word, set `o_data` to its MSB, keep `o_enable` at 1, reset the counter to 0, and stay in SHIFT.
  - Otherwise: set `o_enable` and `o_data` to 0 and go to IDLE.
- `o_done` is registered. It is set for exactly one cycle after every last-bit cycle, including the back-to-back case.
- `i_valid` while `o_ready` = 0 is ignored. The word is not latched, and the source must hold it until accepted.
- Changes to `i_word` during a frame have no effect.

## Timing
- Reset values: `o_data` = 0, `o_enable` = 0, `o_last` = 0, `o_done` = 0, `o_ready` = 0 during reset. The state is IDLE and the counter is 0.
- `o_ready` = 1 in the first cycle after `rst` falls.
- Latency: accept at edge N puts bit WIDTH-1 on `o_data` in cycle N+1. Bit 0 appears in cycle N+WIDTH. `o_done` = 1 in cycle N+WIDTH+1.
- A frame is exactly WIDTH consecutive cycles with `o_enable` = 1. `o_enable` never drops mid-frame. This is required because the receiver clears its contents whenever its `i_enable` is low.
- Back-to-back throughput: one word per WIDTH cycles, with `o_enable` continuously 1.
- When frames are separated by a gap, `o_enable` is 0 for at least one cycle. The receiver clears on that edge, so downstream logic must sample the word while `o_done` = 1.
- Reset mid-frame: the frame is aborted at that edge and all outputs return to their reset values. No `o_done` is produced for the aborted frame.
- Reset together with an accept: reset wins and the word is dropped.

## Test plan
- Reset then idle: hold `rst` for 2 cycles, then `i_valid` = 0 for 10 cycles. Required: `o_enable` = 0, `o_data` = 0, `o_ready` = 1 from the first post-reset cycle.
- Single frame: accept 64'h8000_0000_0000_0001. Required: `o_data` = 1 in cycle 1, 0 in cycles 2–63, 1 in cycle 64 with `o_last` = 1; `o_done` = 1 in cycle 65. The attached receiver outputs 64'h8000_0000_0000_0001 at `o_done`.
- Back-to-back: accept 64'hDEAD_BEEF_0123_4567, then present 64'hFFFF_0000_FFFF_0000 with `i_valid` held high. Required: `o_enable` stays 1 for 128 cycles and `o_done` pulses at cycles 65 and 129. The receiver shows each word at its `o_done`.
- Backpressure: assert `i_valid` with 64'hA5A5… at cycle 10 of an active frame. Required: the word is not accepted until `o_last`, and the current frame bits are unchanged.
- Reset mid-frame: assert `rst` at bit 30. Required: next cycle `o_enable` = 0, `o_done` stays 0, and a new accepted word then transmits from its MSB correctly.
- WIDTH = 8, CW = 3 instance: accept 8'h96. Required: `o_data` sequence is 1,0,0,1,0,1,1,0, `o_last` is high on the 8th bit, and `o_done` is high in cycle 9.

Source files
------------

// File: rtl/piso_serializer64.sv
// Parallel-in, serial-out transmitter: sends a WIDTH-bit word MSB first as a gated serial stream.
// Words are taken over a valid/ready handshake. Back-to-back words leave o_enable high with no gap.
module piso_serializer64 #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_data,
    output logic             o_enable,
    output logic             o_last,
    output logic             o_done
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_SHIFT = 1'b1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [0:0]       state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             en_q, en_nxt;
    logic             done_q, done_nxt;
    logic             accept;

    // The MSB of the shift register is the serial bit, so o_data stays registered and is 0 when idle
    assign o_data   = sreg[WIDTH-1];
    assign o_enable = en_q;
    assign o_done   = done_q;
    assign o_last   = (state == ST_SHIFT) && (cnt == CNT_LAST);
    assign o_ready  = !rst && ((state == ST_IDLE) || o_last);
    assign accept   = i_valid && o_ready;

    // Next-state and datapath decode
    always_comb begin
        state_nxt = state;
        sreg_nxt  = '0;
        cnt_nxt   = cnt;
        en_nxt    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    sreg_nxt  = i_word;
                    en_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt != CNT_LAST) begin
                    sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
                    en_nxt   = 1'b1;
                    cnt_nxt  = cnt + CW'(1);
                end else begin
                    done_nxt = 1'b1;
                    cnt_nxt  = '0;
                    if (accept) begin
                        sreg_nxt = i_word;
                        en_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            sreg   <= '0;
            cnt    <= '0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            sreg   <= sreg_nxt;
            cnt    <= cnt_nxt;
            en_q   <= en_nxt;
            done_q <= done_nxt;
        end
    end

endmodule

// File: tb/tb_piso_serializer64.sv
// Scoreboard bench for piso_serializer64: a 64-bit and an 8-bit instance, each feeding a modelled receiver.
module tb_piso_serializer64;

    localparam int unsigned W  = 64;
    localparam int unsigned W8 = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] i_word;
    logic         i_valid;
    logic         o_ready, o_data, o_enable, o_last, o_done;
    logic [7:0]   i_word8;
    logic         i_valid8;
    logic         o_ready8, o_data8, o_enable8, o_last8, o_done8;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    piso_serializer64 #(.WIDTH(W), .CW(6)) dut (
        .clk(clk), .rst(rst), .i_word(i_word), .i_valid(i_valid), .o_ready(o_ready),
        .o_data(o_data), .o_enable(o_enable), .o_last(o_last), .o_done(o_done)
    );

    piso_serializer64 #(.WIDTH(W8), .CW(3)) dut8 (
        .clk(clk), .rst(rst), .i_word(i_word8), .i_valid(i_valid8), .o_ready(o_ready8),
        .o_data(o_data8), .o_enable(o_enable8), .o_last(o_last8), .o_done(o_done8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver models: shift in while enabled, clear whenever enable is low
    logic [W-1:0] rx  = '0;
    logic [7:0]   rx8 = '0;
    always @(posedge clk) rx  <= o_enable  ? {rx[W-2:0], o_data}   : '0;
    always @(posedge clk) rx8 <= o_enable8 ? {rx8[6:0], o_data8}   : '0;

    // Expected serial bits, words and accept cycles, pushed by the driver
    bit           bit_q[$];
    logic [W-1:0] word_q[$];
    int           acc_q[$];
    bit           bit8_q[$];
    logic [7:0]   word8_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_empty(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got output with empty scoreboard expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor for the 64-bit instance
    int idx       = 0;
    bit prev_last = 1'b0;
    always @(negedge clk) begin : mon64
        bit exp_en;
        bit exp_last;
        if (rst) begin
            check("ready_in_reset", 64'(o_ready), 64'd0);
            bit_q.delete(); word_q.delete(); acc_q.delete();
            idx = 0;
            prev_last = 1'b0;
        end else begin
            exp_en = (idx != 0) || (acc_q.size() > 0 && acc_q[0] == cyc - 1);
            check("enable", 64'(o_enable), 64'(exp_en));
            exp_last = 1'b0;
            if (o_enable) begin
                if (idx == 0 && acc_q.size() > 0) void'(acc_q.pop_front());
                if (bit_q.size() == 0) fail_empty("data");
                else check("data", 64'(o_data), 64'(bit_q.pop_front()));
                exp_last = (idx == W - 1);
                idx = exp_last ? 0 : idx + 1;
            end else begin
                check("data_idle", 64'(o_data), 64'd0);
                idx = 0;
            end
            check("last", 64'(o_last), 64'(exp_last));
            check("ready", 64'(o_ready), 64'(!o_enable || exp_last));
            check("done", 64'(o_done), 64'(prev_last));
            if (o_done) begin
                if (word_q.size() == 0) fail_empty("rx_word");
                else check("rx_word", rx, word_q.pop_front());
            end
            prev_last = exp_last;
        end
    end

    // Monitor for the 8-bit instance
    int idx8       = 0;
    bit prev_last8 = 1'b0;
    always @(negedge clk) begin : mon8
        bit exp_last8;
        if (rst) begin
            bit8_q.delete(); word8_q.delete();
            idx8 = 0;
            prev_last8 = 1'b0;
        end else begin
            exp_last8 = 1'b0;
            if (o_enable8) begin
                if (bit8_q.size() == 0) fail_empty("data8");
                else check("data8", 64'(o_data8), 64'(bit8_q.pop_front()));
                exp_last8 = (idx8 == W8 - 1);
                idx8 = exp_last8 ? 0 : idx8 + 1;
            end else begin
                idx8 = 0;
            end
            check("last8", 64'(o_last8), 64'(exp_last8));
            check("done8", 64'(o_done8), 64'(prev_last8));
            if (o_done8) begin
                if (word8_q.size() == 0) fail_empty("rx_word8");
                else check("rx_word8", 64'(rx8), 64'(word8_q.pop_front()));
            end
            prev_last8 = exp_last8;
        end
    end

    // Drivers: inputs change 1 time unit after the rising edge, the accept is judged at the falling edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] w);
        bit got = 1'b0;
        i_word  = w;
        i_valid = 1'b1;
        for (int t = 0; t < 4 * W && !got; t++) begin
            @(negedge clk);
            if (o_ready && !rst) begin
                for (int i = W - 1; i >= 0; i--) bit_q.push_back(w[i]);
                word_q.push_back(w);
                acc_q.push_back(cyc);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_word  = {$urandom, $urandom};
        if (!got) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send8(input logic [7:0] w);
        bit got = 1'b0;
        i_word8  = w;
        i_valid8 = 1'b1;
        for (int t = 0; t < 4 * W8 && !got; t++) begin
            @(negedge clk);
            if (o_ready8 && !rst) begin
                for (int i = W8 - 1; i >= 0; i--) bit8_q.push_back(w[i]);
                word8_q.push_back(w);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        i_valid8 = 1'b0;
        i_word8  = 8'($urandom);
        if (!got) check("accept8_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        i_word   = '0;
        i_valid  = 1'b0;
        i_word8  = '0;
        i_valid8 = 1'b0;
        rst      = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(10);

        send(64'h8000_0000_0000_0001);
        idle(70);

        send(64'hDEAD_BEEF_0123_4567);
        send(64'hFFFF_0000_FFFF_0000);
        idle(70);

        // Backpressure: a second word offered ten cycles into a frame
        send({$urandom, $urandom});
        idle(9);
        send(64'hA5A5_A5A5_A5A5_A5A5);
        idle(70);

        // Reset in the middle of a frame, then a fresh word
        send({$urandom, $urandom});
        idle(29);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send({$urandom, $urandom});
        idle(70);

        // Random words; gaps straddle the back-to-back boundary
        for (int k = 0; k < 30; k++) begin
            send({$urandom, $urandom});
            idle(W - 1 + $urandom_range(0, 3));
        end
        idle(70);

        send8(8'h96);
        idle(12);
        for (int k = 0; k < 6; k++) begin
            send8(8'($urandom));
            idle($urandom_range(0, 9));
        end
        idle(20);

        check("bits_drained", 64'(bit_q.size()), 64'd0);
        check("words_drained", 64'(word_q.size()), 64'd0);
        check("bits8_drained", 64'(bit8_q.size()), 64'd0);
        check("words8_drained", 64'(word8_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end of test expected completion (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
